// File: rtl/sync_signal_core_pkg.sv
// sync_signal_core_pkg: parameter limits and filter counter sizing for sync_signal_core
package sync_signal_core_pkg;
   localparam int STAGES_MIN = 2;
   localparam int STAGES_MAX = 8;
   localparam int FILTER_MAX = 255;
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/sync_signal_core_if.sv
// sync_signal_core_if: raw input pin and synchronized level/strobe outputs
interface sync_signal_core_if;
   logic i_in;
   logic o_out;
   logic o_rising;
   logic o_falling;
   modport master (output i_in, input o_out, o_rising, o_falling);
   modport slave (input i_in, output o_out, o_rising, o_falling);
endinterface

// File: rtl/sync_signal_core_chain.sv
// sync_chain: STAGES-deep resettable synchronizer flop chain; only r_s[0] samples the async input
module sync_chain #(
   parameter int STAGES = 2,
   parameter bit RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_s;
   always_ff @(posedge clk)
      if (rst) r_s <= {STAGES{RESET_VALUE}};
      else r_s <= {r_s[STAGES-2:0], i_d};
   assign o_q = r_s[STAGES-1];
endmodule

// File: rtl/sync_signal_core.sv
// sync_signal_core: input synchronizer with optional glitch filter and rising/falling strobes
module sync_signal_core
   import sync_signal_core_pkg::*;
#(
   parameter int STAGES = 2,
   parameter bit RESET_VALUE = 1'b0,
   parameter int FILTER_LEN = 0
) (
   input logic clk,
   input logic rst,
   sync_signal_core_if.slave bus
);
   localparam int CW = cnt_w(FILTER_LEN);
   logic w_ss;
   logic w_out;
   logic r_prev;
   if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("sync_signal_core: STAGES out of range");
   end
   if (FILTER_LEN < 0 || FILTER_LEN > FILTER_MAX) begin : g_bad_filter
      $error("sync_signal_core: FILTER_LEN out of range");
   end
   sync_chain #(.STAGES(STAGES), .RESET_VALUE(RESET_VALUE)) u_chain (
      .clk(clk),
      .rst(rst),
      .i_d(bus.i_in),
      .o_q(w_ss)
   );
   if (FILTER_LEN == 0) begin : g_bypass
      assign w_out = w_ss;
   end else begin : g_filter
      logic          r_lvl;
      logic [CW-1:0] r_cnt;
      // lvl follows ss only after ss has disagreed for FILTER_LEN consecutive cycles
      always_ff @(posedge clk)
         if (rst) begin
            r_lvl <= RESET_VALUE;
            r_cnt <= '0;
         end else if (w_ss == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_lvl <= w_ss;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      assign w_out = r_lvl;
   end
   always_ff @(posedge clk)
      if (rst) r_prev <= RESET_VALUE;
      else r_prev <= w_out;
   assign bus.o_out     = w_out;
   assign bus.o_rising  = w_out & ~r_prev;
   assign bus.o_falling = ~w_out & r_prev;
endmodule

// File: tb/tb_sync_signal_core.sv
// tb_sync_signal_core: scoreboard bench over three configurations driven with a shared stimulus
module tb_sync_signal_core;
   typedef struct {
      int   d;
      logic o;
      logic r;
      logic f;
   } exp_t;
   localparam int ND = 3;
   localparam int ST [ND] = '{2, 2, 3};
   localparam int FL [ND] = '{0, 3, 0};
   localparam bit RV [ND] = '{1'b0, 1'b0, 1'b1};
   logic clk = 1'b0;
   logic rst;
   sync_signal_core_if b0 ();
   sync_signal_core_if b1 ();
   sync_signal_core_if b2 ();
   sync_signal_core #(.STAGES(2), .RESET_VALUE(1'b0), .FILTER_LEN(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   sync_signal_core #(.STAGES(2), .RESET_VALUE(1'b0), .FILTER_LEN(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   sync_signal_core #(.STAGES(3), .RESET_VALUE(1'b1), .FILTER_LEN(0)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
   always #5 clk = ~clk;
   logic [ND-1:0] g_out, g_rise, g_fall;
   assign g_out  = {b2.o_out, b1.o_out, b0.o_out};
   assign g_rise = {b2.o_rising, b1.o_rising, b0.o_rising};
   assign g_fall = {b2.o_falling, b1.o_falling, b0.o_falling};
   int   n_chk = 0;
   int   n_fail = 0;
   int   t = 0;
   int   win = 0;
   int   n_rise0 = 0, n_fall0 = 0, n_hi1 = 0, n_rise1 = 0, n_fall1 = 0, n_rise2 = 0;
   logic in_h [0:1023];
   logic rst_h [0:1023];
   logic out_h [ND][0:1023];
   exp_t sb [$];
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
      end
   endtask
   // synchronized sample after edge k: the input sampled STAGES-1 edges earlier, unless a reset edge intervened
   function automatic logic ss_at(input int st, input logic rv, input int k);
      for (int j = k - st + 1; j <= k; j++)
         if (j < 0 || rst_h[j]) return rv;
      return in_h[k - st + 1];
   endfunction
   task automatic tick(input logic v, input logic r);
      logic o, p, all;
      exp_t e;
      b0.i_in = v;
      b1.i_in = v;
      b2.i_in = v;
      rst = r;
      in_h[t] = v;
      rst_h[t] = r;
      for (int d = 0; d < ND; d++) begin
         p = (t == 0) ? RV[d] : out_h[d][t-1];
         if (r) o = RV[d];
         else if (FL[d] == 0) o = ss_at(ST[d], RV[d], t);
         else begin
            all = (t - FL[d] >= 0);
            for (int j = t - FL[d]; j < t; j++)
               if (j < 0 || ss_at(ST[d], RV[d], j) != ~p) all = 1'b0;
            o = all ? ~p : p;
         end
         out_h[d][t] = o;
         e.d = d;
         e.o = o;
         e.r = ~r & o & ~p;
         e.f = ~r & ~o & p;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk($sformatf("out%0d", e.d), int'(g_out[e.d]), int'(e.o));
         chk($sformatf("rise%0d", e.d), int'(g_rise[e.d]), int'(e.r));
         chk($sformatf("fall%0d", e.d), int'(g_fall[e.d]), int'(e.f));
         chk($sformatf("excl%0d", e.d), int'(g_rise[e.d] & g_fall[e.d]), 0);
      end
      if (win == 1) begin
         n_rise0 += int'(g_rise[0]);
         n_fall0 += int'(g_fall[0]);
      end
      if (win == 2) begin
         n_hi1 += int'(g_out[1]);
         n_rise1 += int'(g_rise[1]);
         n_fall1 += int'(g_fall[1]);
      end
      n_rise2 += int'(g_rise[2]);
      t++;
   endtask
   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) tick(v, 1'b0);
   endtask
   initial begin
      rst = 1'b1;
      b0.i_in = 1'b1;
      b1.i_in = 1'b1;
      b2.i_in = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
      chk("rst_out0", int'(g_out[0]), 0);
      chk("rst_out2", int'(g_out[2]), 1);
      tick(1'b1, 1'b0);
      chk("rel_out0", int'(g_out[0]), 0);
      chk("rel_rise0", int'(g_rise[0]), 0);
      tick(1'b1, 1'b0);
      chk("rel2_rise0", int'(g_rise[0]), 1);
      hold(1'b1, 8);
      hold(1'b0, 10);
      hold(1'b1, 10);
      hold(1'b0, 10);
      win = 1;
      for (int i = 0; i < 8; i++) tick(i[0] ? 1'b0 : 1'b1, 1'b0);
      hold(1'b0, 6);
      win = 0;
      chk("tog_rise", n_rise0, 4);
      chk("tog_fall", n_fall0, 4);
      hold(1'b1, 2);
      hold(1'b0, 10);
      chk("glitch2_out1", int'(g_out[1]), 0);
      win = 2;
      hold(1'b1, 3);
      hold(1'b0, 12);
      win = 0;
      chk("pulse3_hi1", n_hi1, 3);
      chk("pulse3_rise1", n_rise1, 1);
      chk("pulse3_fall1", n_fall1, 1);
      n_rise2 = 0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      hold(1'b1, 6);
      hold(1'b0, 8);
      tick(1'b0, 1'b1);
      hold(1'b0, 4);
      chk("rv1_out2", int'(g_out[2]), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout t=%0d", t);
      $fatal(1, "timeout");
   end
endmodule
